hazard_sequencer: RTL
=====================

// Module: hazard_sequencer
// PURPOSE
//  Pipeline hazard controller for the 5-stage RV32 core. Computes operand
//  forwarding, load-use stalls and branch/jump flushes, and sequences
//  whole-pipe stalls while data memory is busy. Drives the stall and flush
//  inputs of the F/D/E/M pipeline registers. Keeps saturating stall and
//  flush performance counters.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive DMemBusy cycles tolerated before HALT
//  CNT_W        16  width of the performance counters
// PORTS
//  clk         in   1      clock
//  rst         in   1      asynchronous, active-low reset
//  RS1_D,RS2_D in   5      source regs of the instruction in Decode
//  RS1_E,RS2_E in   5      source regs of the instruction in Execute
//  RD_E        in   5      dest reg in Execute
//  RegWriteE   in   1      Execute writes a register
//  ResultSrcE  in   1      Execute instruction is a load
//  PCSrcE      in   1      branch taken or jump in Execute
//  RD_M,RD_W   in   5      dest regs in Memory and Writeback
//  RegWriteM/W in   1      Memory and Writeback write a register
//  DMemBusy    in   1      data memory not ready; Memory stage must hold
//  CntClr      in   1      synchronous clear of both counters
//  StallF,StallD,StallE,StallM out 1  hold the corresponding pipe register
//  FlushD,FlushE out 1     clear the IF/ID and ID/EX registers (bubble)
//  ForwardAE,ForwardBE out 2  00=regfile, 01=ResultW, 10=ALUResultM
//  Halted      out  1      sticky memory-timeout flag
//  StallCnt,FlushCnt out CNT_W  performance counters
// BEHAVIOUR
//  - Outputs are combinational from state and inputs. Only state, wait_cnt,
//    Halted and the counters are registers.
//  - Reset: state=RUN, wait_cnt=0, Halted=0, counters=0. All stall and flush
//    outputs read 0 during reset. Forward outputs stay combinational.
//  - Forwarding, A side (B side identical with RS2_E):
//    10 if RegWriteM & RD_M!=0 & RD_M==RS1_E;
//    else 01 if RegWriteW & RD_W!=0 & RD_W==RS1_E; else 00.
//    M has priority over W. Forwarding is evaluated in every state.
//  - lwStall = ResultSrcE & RegWriteE & RD_E!=0 & (RD_E==RS1_D | RD_E==RS2_D).
//  - FSM states: RUN, MEMWAIT, HALT. Priority within RUN: DMemBusy > PCSrcE > lwStall.
//    RUN, DMemBusy=1: StallF/D/E/M=1, no flush; next MEMWAIT, wait_cnt<=1.
//    RUN, PCSrcE=1: FlushD=FlushE=1, no stall; stay RUN.
//    RUN, lwStall=1: StallF=StallD=1, FlushE=1; stay RUN. The bubble makes
//      lwStall drop the next cycle, so the stall lasts exactly 1 cycle.
//    RUN, none of the above: all stall and flush outputs 0.
//    MEMWAIT, DMemBusy=1: StallF/D/E/M=1, no flush. If wait_cnt==MEM_TIMEOUT,
//      next HALT and Halted<=1; else wait_cnt<=wait_cnt+1.
//    MEMWAIT, DMemBusy=0: outputs follow the RUN rules this same cycle (the
//      held PCSrcE/lwStall now act). Next RUN, wait_cnt<=0.
//    HALT: StallF/D/E/M=1, FlushD=FlushE=0. Left only by reset.
//  - Simultaneous PCSrcE and DMemBusy: stall wins. Execute is held, so the
//    redirect and flush occur in the first cycle busy is low.
//  - Counters: StallCnt +1 each cycle StallF=1 outside HALT. FlushCnt +1 each
//    cycle FlushD=1. Both saturate at all-ones. CntClr takes priority over
//    increment and clears to 0.
//  - Reset mid-MEMWAIT or mid-HALT returns to RUN with all state cleared.
// TESTING
//  1 RS1_E=5, RegWriteM=1, RD_M=5, RegWriteW=1, RD_W=5 -> ForwardAE=10;
//    RD_M=0 -> 01; RegWriteW=0 -> 00.
//  2 Load in E (RD_E=7), RS2_D=7 -> StallF=StallD=FlushE=1 for exactly 1
//    cycle; StallCnt=1.
//  3 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=0; FlushCnt +1.
//  4 MEM_TIMEOUT=8, DMemBusy high 8 cycles -> stalls 8 cycles, RUN on cycle 9,
//    Halted=0. High 9 cycles -> Halted=1, all stalls stuck at 1.
//  5 PCSrcE=1 with DMemBusy high 3 cycles -> no flush for 3 cycles, then
//    FlushD=FlushE=1 in cycle 4.
//  6 CNT_W=4: 20 stall cycles -> StallCnt=15; CntClr -> 0. Reset during HALT
//    -> Halted=0, state RUN.

Source files
------------

// File: rtl/hazard_sequencer.sv
// Hazard controller for the 5-stage RV32 pipe: operand forwarding, load-use
// stalls, branch flushes, data-memory wait sequencing and perf counters.
module hazard_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RS1_E,
  input  logic [4:0]       RS2_E,
  input  logic [4:0]       RD_E,
  input  logic             RegWriteE,
  input  logic             ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             DMemBusy,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Halted,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

  localparam int WCW = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MEM_TIMEOUT);

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           lw_stall;

  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == RS1_E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == RS1_E)) ForwardAE = 2'b01;
  end

  always_comb begin
    ForwardBE = 2'b00;
    if (RegWriteM && (RD_M != '0) && (RD_M == RS2_E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RD_W != '0) && (RD_W == RS2_E)) ForwardBE = 2'b01;
  end

  assign lw_stall = ResultSrcE && RegWriteE && (RD_E != '0) &&
                    ((RD_E == RS1_D) || (RD_E == RS2_D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (DMemBusy) state_nxt = MEMWAIT;
      MEMWAIT: begin
        if (!DMemBusy)              state_nxt = RUN;
        else if (wait_cnt == WAIT_MAX) state_nxt = HALT;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // A MEMWAIT cycle with busy low falls through to the RUN rules, so held
  // redirects and load-use bubbles take effect in the release cycle itself.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      if ((state == HALT) || DMemBusy) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      Halted   <= 1'b0;
    end else begin
      case (state)
        RUN:     wait_cnt <= DMemBusy ? WCW'(1) : '0;
        MEMWAIT: begin
          if (!DMemBusy)                 wait_cnt <= '0;
          else if (wait_cnt == WAIT_MAX) Halted   <= 1'b1;
          else                           wait_cnt <= wait_cnt + WCW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else if (CntClr) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (state != HALT) && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && (FlushCnt != '1))                    FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule
